usb_pkt_wr_ctrl: RTL

Write-side packet sequencer for the 256-word dual-clock DAC sample cache. It runs in the `wrclock` (USB3 FIFO) domain and takes the 32-bit word stream while the USB read FSM is in its data phase. It strips and decodes the packet header word, writes the payload words into the cache at a wrapping write address, and hands each completed packet (type, base address) to the read-side sequencer over a level req/ack handshake.

---
 rtl/usb_da_pkg.sv | 28 ++
 rtl/usb_hdr_decode.sv | 31 +++
 rtl/usb_pkt_wr_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/usb_da_pkg.sv
// Shared constants and types for the USB DAC sample-cache packet path.
// Used by both the write-side and read-side sequencers.
package usb_da_pkg;

    localparam logic [31:0] HDR_MASK = 32'hFF0000FF;

    localparam logic [15:0] TYPE_CODE_1 = 16'h0000;
    localparam logic [15:0] TYPE_CODE_2 = 16'h000A;
    localparam logic [15:0] TYPE_CODE_3 = 16'h00AA;
    localparam logic [15:0] TYPE_CODE_4 = 16'h0AAA;
    localparam logic [15:0] TYPE_CODE_5 = 16'hAAAA;

    typedef enum logic [3:0] {
        PKT_NONE = 4'd0,
        PKT_T1   = 4'd1,
        PKT_T2   = 4'd2,
        PKT_T3   = 4'd3,
        PKT_T4   = 4'd4,
        PKT_T5   = 4'd5
    } pkt_type_t;

    localparam logic [3:0] DATA_PHASE = 4'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_HDR = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;

endpackage

// File: rtl/usb_hdr_decode.sv
// Combinational packet-header match and type decode.
// hdr_type is PKT_NONE when the word is not a header or carries an unknown code.
module usb_hdr_decode
    import usb_da_pkg::*;
(
    input  logic [31:0] data,
    output logic        is_hdr,
    output logic        hdr_ok,
    output logic [3:0]  hdr_type
);

    pkt_type_t t;

    always_comb begin
        is_hdr = ((data & HDR_MASK) == HDR_MASK);
        t      = PKT_NONE;
        if (is_hdr) begin
            case (data[23:8])
                TYPE_CODE_1: t = PKT_T1;
                TYPE_CODE_2: t = PKT_T2;
                TYPE_CODE_3: t = PKT_T3;
                TYPE_CODE_4: t = PKT_T4;
                TYPE_CODE_5: t = PKT_T5;
                default:     t = PKT_NONE;
            endcase
        end
        hdr_ok   = is_hdr && (t != PKT_NONE);
        hdr_type = t;
    end

endmodule

// File: rtl/usb_pkt_wr_ctrl.sv
// Write-side packet sequencer: strips/decodes the header, writes payload into the
// sample cache at a wrapping address and hands finished packets off via req/ack.
module usb_pkt_wr_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned PAY_LEN    = 128,
    parameter logic [3:0]  DATA_PHASE = usb_da_pkg::DATA_PHASE
) (
    input  logic              wrclock,
    input  logic              rst_n,
    input  logic [3:0]        usb_rd_state,
    input  logic [31:0]       data,
    input  logic              pkt_ack,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [31:0]       wr_data,
    output logic              pkt_req,
    output logic [3:0]        pkt_type,
    output logic [ADDR_W-1:0] pkt_base,
    output logic              pkt_err,
    output logic [1:0]        err_code
);
    import usb_da_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HANDOFF,
        S_WAIT_ACK,
        S_ACK_LOW
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              is_hdr;
    logic              hdr_ok;
    logic [3:0]        hdr_type;

    assign accept = (usb_rd_state == DATA_PHASE);

    usb_hdr_decode u_hdr_decode (
        .data     (data),
        .is_hdr   (is_hdr),
        .hdr_ok   (hdr_ok),
        .hdr_type (hdr_type)
    );

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wren      <= 1'b0;
            wraddress <= '0;
            wr_data   <= '0;
            pkt_req   <= 1'b0;
            pkt_type  <= '0;
            pkt_base  <= '0;
            pkt_err   <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            wren    <= 1'b0;
            pkt_err <= 1'b0;
            // Address advances the cycle after a write is presented, so wraddress
            // always shows the write address alongside wren and the next free slot otherwise.
            if (wren) wraddress <= wraddress + ADDR_W'(1);

            case (state)
                S_IDLE: begin
                    if (accept && is_hdr) begin
                        if (hdr_ok) begin
                            pkt_type <= hdr_type;
                            pkt_base <= wraddress;
                            cnt      <= '0;
                            state    <= S_PAYLOAD;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_BAD_HDR;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        wren    <= 1'b1;
                        wr_data <= data;
                        if (cnt == ADDR_W'(PAY_LEN - 1)) state <= S_HANDOFF;
                        else                             cnt   <= cnt + ADDR_W'(1);
                    end
                end
                S_HANDOFF: begin
                    pkt_req <= 1'b1;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (pkt_ack) begin
                        pkt_req <= 1'b0;
                        state   <= S_ACK_LOW;
                    end
                end
                S_ACK_LOW: begin
                    if (!pkt_ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Any header arriving while a packet is still held is dropped as an overrun.
            if (accept && is_hdr &&
                (state == S_HANDOFF || state == S_WAIT_ACK || state == S_ACK_LOW)) begin
                pkt_err  <= 1'b1;
                err_code <= ERR_OVERRUN;
            end
        end
    end

endmodule
